// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
package dmem_pkg;

    // Access size codes as presented on req_size.
    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_RSV = 2'b11
    } size_e;

    // MIPS exception codes for address errors on load / store.
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;

    // Controller FSM: one request walks IDLE -> ACCESS -> CAPTURE -> RESP.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ACCESS  = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_RESP    = 2'b11
    } state_e;

endpackage

// File: rtl/dmem_ctrl_if.sv
// Core-side load/store request and response bus of the data-memory controller.
interface dmem_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_rdata;
    logic                  resp_err;
    logic [4:0]            resp_excode;
    logic [ADDR_WIDTH-1:0] resp_badvaddr;

    // Core side: issues requests, consumes responses.
    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err, resp_excode, resp_badvaddr,
        output resp_ready
    );

    // Controller side.
    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err, resp_excode, resp_badvaddr,
        input  resp_ready
    );
endinterface

// File: rtl/dmem_align.sv
// Combinational lane logic: store byte enables and data replication, load
// lane extraction with sign/zero extension, and misalignment detection.
module dmem_align
    import dmem_pkg::*;
(
    input  size_e       size_i,
    input  logic        signed_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] ram_dout_i,
    output logic [3:0]  wea_o,
    output logic [31:0] din_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    // Little-endian byte lanes of the RAM read word.
    logic [7:0] lane [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = ram_dout_i[8*gi +: 8];
        end
    endgenerate

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = lane[addr_lo_i];
    assign half_sel = addr_lo_i[1] ? {lane[3], lane[2]} : {lane[1], lane[0]};

    // Per-size enables, replicated store data, extended load data, alignment.
    always_comb begin
        wea_o      = 4'b0000;
        din_o      = wdata_i;
        rdata_o    = 32'h0;
        misalign_o = 1'b0;
        case (size_i)
            SZ_B: begin
                wea_o   = 4'b0001 << addr_lo_i;
                din_o   = {4{wdata_i[7:0]}};
                rdata_o = signed_i ? {{24{byte_sel[7]}}, byte_sel}
                                   : {24'h0, byte_sel};
            end
            SZ_H: begin
                misalign_o = addr_lo_i[0];
                wea_o      = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                din_o      = {2{wdata_i[15:0]}};
                rdata_o    = signed_i ? {{16{half_sel[15]}}, half_sel}
                                      : {16'h0, half_sel};
            end
            SZ_W: begin
                misalign_o = (addr_lo_i != 2'b00);
                wea_o      = 4'b1111;
                din_o      = wdata_i;
                rdata_o    = ram_dout_i;
            end
            default: begin
                // Reserved size is always treated as an address error.
                misalign_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: accepts one load/store at a time from the
// core, drives the block RAM for one cycle, and returns an extended load
// value or an address exception.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clka,
    input  logic                  rst,
    dmem_ctrl_if.slave            bus,
    output logic                  ram_en,
    output logic [3:0]            ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_din,
    input  logic [31:0]           ram_dout
);

    state_e                state_q,    state_d;
    logic                  we_q,       we_d;
    size_e                 size_q,     size_d;
    logic                  signed_q,   signed_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [31:0]           wdata_q,    wdata_d;
    logic [31:0]           rdata_q,    rdata_d;
    logic                  err_q,      err_d;
    logic [4:0]            excode_q,   excode_d;
    logic [ADDR_WIDTH-1:0] badvaddr_q, badvaddr_d;

    logic [3:0]  lane_wea;
    logic [31:0] lane_din;
    logic [31:0] lane_rdata;
    logic        misalign;

    // Lane logic works entirely from the captured request, so the request
    // inputs only need to be valid in the accept cycle.
    dmem_align u_align (
        .size_i     (size_q),
        .signed_i   (signed_q),
        .addr_lo_i  (addr_q[1:0]),
        .wdata_i    (wdata_q),
        .ram_dout_i (ram_dout),
        .wea_o      (lane_wea),
        .din_o      (lane_din),
        .rdata_o    (lane_rdata),
        .misalign_o (misalign)
    );

    // State and captured request / response registers.
    always_ff @(posedge clka) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            size_q     <= SZ_B;
            signed_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
            excode_q   <= 5'h0;
            badvaddr_q <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            size_q     <= size_d;
            signed_q   <= signed_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            excode_q   <= excode_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    // Next-state logic: capture in IDLE, build the response in CAPTURE.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        size_d     = size_q;
        signed_d   = signed_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        excode_d   = excode_q;
        badvaddr_d = badvaddr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d     = bus.req_we;
                    size_d   = size_e'(bus.req_size);
                    signed_d = bus.req_signed;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    state_d  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                err_d = misalign;
                if (misalign) begin
                    rdata_d    = 32'h0;
                    excode_d   = we_q ? EXC_ADES : EXC_ADEL;
                    badvaddr_d = addr_q;
                end else begin
                    rdata_d    = we_q ? 32'h0 : lane_rdata;
                    excode_d   = 5'h0;
                    badvaddr_d = '0;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // RAM strobes are gated by rst so a store caught by reset is never written.
    assign ram_en   = rst && (state_q == ST_ACCESS) && !misalign;
    assign ram_wea  = (ram_en && we_q) ? lane_wea : 4'b0000;
    assign ram_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign ram_din  = lane_din;

    assign bus.req_ready     = rst && (state_q == ST_IDLE);
    assign bus.resp_valid    = (state_q == ST_RESP);
    assign bus.resp_rdata    = rdata_q;
    assign bus.resp_err      = err_q;
    assign bus.resp_excode   = excode_q;
    assign bus.resp_badvaddr = badvaddr_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: a stimulus process issues requests and
// pushes expected responses; a monitor pops and compares on each handshake.
module tb_dmem_ctrl;

    logic        clka;
    logic        rst;
    logic        ram_en;
    logic [3:0]  ram_wea;
    logic [31:0] ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    dmem_ctrl_if #(.ADDR_WIDTH(32)) bus ();

    dmem_ctrl #(.ADDR_WIDTH(32)) dut (
        .clka     (clka),
        .rst      (rst),
        .bus      (bus.slave),
        .ram_en   (ram_en),
        .ram_wea  (ram_wea),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    // Behavioural block RAM with a preload port for the bench.
    logic [31:0] mem [0:63];
    logic [31:0] ram_dout_q;
    logic        pre_we;
    logic [5:0]  pre_idx;
    logic [31:0] pre_val;

    always @(posedge clka) begin
        if (pre_we) begin
            mem[pre_idx] <= pre_val;
        end else if (ram_en) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_wea[i]) mem[ram_addr[7:2]][8*i +: 8] <= ram_din[8*i +: 8];
            end
            ram_dout_q <= mem[ram_addr[7:2]];
        end
    end
    assign ram_dout = ram_dout_q;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [4:0]  excode;
        logic [31:0] badvaddr;
    } exp_t;

    exp_t exp_q [$];
    exp_t mon_e;
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_resp  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    function automatic exp_t mk(input logic [31:0] rd, input logic er,
                                input logic [4:0] ex, input logic [31:0] bad);
        exp_t e;
        e.rdata = rd; e.err = er; e.excode = ex; e.badvaddr = bad;
        return e;
    endfunction

    // Monitor: one comparison set per completed response handshake.
    always @(negedge clka) begin
        if (bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) begin
            n_resp++;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_resp: got rdata %h err %b, required no response",
                         bus.resp_rdata, bus.resp_err);
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp_rdata", bus.resp_rdata, mon_e.rdata);
                chk("resp_err", {31'h0, bus.resp_err}, {31'h0, mon_e.err});
                chk("resp_excode", {27'h0, bus.resp_excode}, {27'h0, mon_e.excode});
                chk("resp_badvaddr", bus.resp_badvaddr, mon_e.badvaddr);
                $display("resp: rdata=%h err=%b excode=%h badvaddr=%h",
                         bus.resp_rdata, bus.resp_err, bus.resp_excode, bus.resp_badvaddr);
            end
        end
    end

    task automatic drive_req(input logic we, input logic [1:0] sz, input logic sg,
                             input logic [31:0] a, input logic [31:0] wd);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
    endtask

    // Issue one request (called at posedge+1 in IDLE) and check RAM strobes
    // in ACCESS and response timing; the monitor checks the payload.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, input exp_t e,
                          input logic exp_en, input logic [3:0] exp_wea,
                          input logic [31:0] exp_din);
        int start;
        start = n_resp;
        exp_q.push_back(e);
        drive_req(we, sz, sg, a, wd);
        @(negedge clka);
        chk("req_ready_idle", {31'h0, bus.req_ready}, 32'h1);
        @(posedge clka); #1;
        bus.req_valid = 1'b0;
        bus.req_wdata = 32'h0;
        @(negedge clka);
        chk("ram_en", {31'h0, ram_en}, {31'h0, exp_en});
        chk("ram_wea", {28'h0, ram_wea}, {28'h0, exp_wea});
        if (exp_en) begin
            chk("ram_addr", ram_addr, {a[31:2], 2'b00});
            if (we) chk("ram_din", ram_din, exp_din);
        end
        @(negedge clka);
        chk("resp_valid_c2", {31'h0, bus.resp_valid}, 32'h0);
        @(negedge clka);
        chk("resp_valid_c3", {31'h0, bus.resp_valid}, 32'h1);
        @(posedge clka); #1;
        chk("resp_seen", n_resp, start + 1);
        $display("req: we=%b size=%b signed=%b addr=%h wdata=%h", we, sz, sg, a, wd);
    endtask

    initial begin
        rst = 1'b0;
        pre_we = 1'b0; pre_idx = '0; pre_val = '0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.resp_ready = 1'b1;

        // Reset with RAM preload.
        @(posedge clka); #1;
        pre_we = 1'b1; pre_idx = 6'd4; pre_val = 32'h8BADF00D;
        @(posedge clka); #1;
        pre_idx = 6'd8; pre_val = 32'h55AA55AA;
        @(posedge clka); #1;
        pre_we = 1'b0;
        @(negedge clka);
        chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
        chk("rst_ram_en", {31'h0, ram_en}, 32'h0);
        chk("rst_ram_wea", {28'h0, ram_wea}, 32'h0);
        @(posedge clka); #1;
        rst = 1'b1;
        @(negedge clka);
        chk("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
        @(posedge clka); #1;

        // Stores and loads, hand-computed.
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, mk(32'h0, 1'b0, 5'h0, 32'h0), 1'b1, 4'b1111, 32'hDEADBEEF);
        chk("mem_after_sw", mem[4], 32'hDEADBEEF);
        do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, mk(32'hFFFFFFDE, 1'b0, 5'h0, 32'h0), 1'b1, 4'b0000, 32'h0);
        do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, mk(32'h000000DE, 1'b0, 5'h0, 32'h0), 1'b1, 4'b0000, 32'h0);
        do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, mk(32'hFFFFBEEF, 1'b0, 5'h0, 32'h0), 1'b1, 4'b0000, 32'h0);
        do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, mk(32'h0000DEAD, 1'b0, 5'h0, 32'h0), 1'b1, 4'b0000, 32'h0);
        do_req(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, mk(32'hFFFFFFEF, 1'b0, 5'h0, 32'h0), 1'b1, 4'b0000, 32'h0);
        do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, mk(32'h000000BE, 1'b0, 5'h0, 32'h0), 1'b1, 4'b0000, 32'h0);
        do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234, mk(32'h0, 1'b0, 5'h0, 32'h0), 1'b1, 4'b1100, 32'h12341234);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, mk(32'h1234BEEF, 1'b0, 5'h0, 32'h0), 1'b1, 4'b0000, 32'h0);
        do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AB, mk(32'h0, 1'b0, 5'h0, 32'h0), 1'b1, 4'b0010, 32'hABABABAB);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, mk(32'h1234ABEF, 1'b0, 5'h0, 32'h0), 1'b1, 4'b0000, 32'h0);
        do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, mk(32'h00001234, 1'b0, 5'h0, 32'h0), 1'b1, 4'b0000, 32'h0);

        // Misaligned and reserved-size accesses.
        do_req(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, mk(32'h0, 1'b1, 5'h04, 32'h11), 1'b0, 4'b0000, 32'h0);
        do_req(1'b1, 2'b01, 1'b0, 32'h13, 32'h0000FFFF, mk(32'h0, 1'b1, 5'h05, 32'h13), 1'b0, 4'b0000, 32'h0);
        chk("mem_after_bad_sh", mem[4], 32'h1234ABEF);
        do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, mk(32'h0, 1'b1, 5'h04, 32'h10), 1'b0, 4'b0000, 32'h0);

        // Back-pressure: hold resp_ready low for 5 cycles while a store is offered.
        bus.resp_ready = 1'b0;
        exp_q.push_back(mk(32'h1234ABEF, 1'b0, 5'h0, 32'h0));
        drive_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        @(posedge clka); #1;
        bus.req_valid = 1'b0;
        @(negedge clka);
        @(negedge clka);
        @(negedge clka);
        chk("stall_valid_0", {31'h0, bus.resp_valid}, 32'h1);
        for (int k = 1; k < 5; k++) begin
            @(posedge clka); #1;
            drive_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D);
            @(negedge clka);
            chk("stall_valid", {31'h0, bus.resp_valid}, 32'h1);
            chk("stall_req_ready", {31'h0, bus.req_ready}, 32'h0);
            chk("stall_rdata", bus.resp_rdata, 32'h1234ABEF);
            chk("stall_ram_en", {31'h0, ram_en}, 32'h0);
        end
        @(posedge clka); #1;
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clka); #1;
        @(negedge clka);
        chk("post_stall_req_ready", {31'h0, bus.req_ready}, 32'h1);
        chk("post_stall_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        chk("stall_store_ignored", mem[8], 32'h55AA55AA);
        @(posedge clka); #1;

        // Reset during ACCESS of a store: no write, no response.
        drive_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hFFFFFFFF);
        @(posedge clka); #1;
        bus.req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clka);
        chk("rst_access_ram_en", {31'h0, ram_en}, 32'h0);
        chk("rst_access_ram_wea", {28'h0, ram_wea}, 32'h0);
        @(posedge clka); #1;
        @(negedge clka);
        chk("rst2_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        chk("rst2_resp_rdata", bus.resp_rdata, 32'h0);
        chk("rst2_resp_err", {31'h0, bus.resp_err}, 32'h0);
        chk("rst2_badvaddr", bus.resp_badvaddr, 32'h0);
        @(posedge clka); #1;
        rst = 1'b1;
        @(negedge clka);
        chk("rst2_req_ready", {31'h0, bus.req_ready}, 32'h1);
        chk("rst_store_dropped", mem[8], 32'h55AA55AA);
        repeat (6) @(posedge clka);
        #1;
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required finish before 100000");
        $fatal(1);
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory access controller between the mips core's load/store port and the data_ram block RAM.
- Accepts one valid/ready load or store request at a time.
- Generates byte-lane write enables and store-data replication for sb/sh/sw, and extracts plus sign/zero-extends loaded data for lb/lbu/lh/lhu/lw.
- Detects misaligned accesses and raises an address exception instead of touching RAM.

Parameters:
ADDR_WIDTH, 32, width of request address, ram_addr and resp_badvaddr.

Ports:
clka  input  1  clock; every register updates on the rising edge.
rst  input  1  reset, synchronous, active-low.
req_valid  input  1  core request valid.
req_ready  output  1  controller can accept a request.
req_we  input  1  1 = store, 0 = load.
req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
req_signed  input  1  load sign-extends when 1; ignored for stores and words.
req_addr  input  ADDR_WIDTH  byte address.
req_wdata  input  32  store data, right-justified.
resp_valid  output  1  response available.
resp_ready  input  1  core accepts the response.
resp_rdata  output  32  extended load data; 0 for stores and errors.
resp_err  output  1  address exception.
resp_excode  output  5  0x04 AdEL (load), 0x05 AdES (store), 0 otherwise.
resp_badvaddr  output  ADDR_WIDTH  faulting address; 0 when no error.
ram_en  output  1  RAM enable.
ram_wea  output  4  RAM byte write enables; bit i covers data[8i+7:8i].
ram_addr  output  ADDR_WIDTH  word-aligned byte address {addr[AW-1:2],2'b00}.
ram_din  output  32  RAM write data.
ram_dout  input  32  RAM read data, valid one cycle after ram_en is sampled (same clka edge, no inverted clock).

Behaviour:
- Clock and reset: one clock, clka; reset rst is synchronous, active-low.
- Reset (rst=0 at a rising edge): state goes to IDLE; all registered outputs are 0; req_ready=1 from the first cycle after rst returns high.
- Reset gating: ram_en and ram_wea are additionally gated combinationally by rst. A store sitting in ACCESS during a cycle with rst=0 is therefore never written. A reset mid-operation drops the in-flight request with no response.
- FSM is IDLE -> ACCESS -> CAPTURE -> RESP -> IDLE.
- IDLE: req_ready=1. On req_valid=1 the controller captures we, size, signed, addr and wdata, runs the alignment check, and goes to ACCESS. Request inputs need only be valid in the accept cycle.
- ACCESS (cycle 1 after accept): ram_en=1 and ram_addr/ram_wea/ram_din are driven from registers, unless the request is misaligned, in which case ram_en=0 and ram_wea=0.
- CAPTURE (cycle 2): ram_dout is valid. The controller registers the extended load data and error fields, then goes to RESP.
- RESP (cycle 3): resp_valid=1 and all resp_* held stable until resp_ready=1. In that cycle it returns to IDLE.
- Timing: minimum accept-to-resp_valid latency is 3 cycles; throughput is 1 request per 4 cycles.
- req_valid outside IDLE is ignored (req_ready=0).
- Byte order is little-endian: addr[1:0]=0 selects lane 0.
- Stores:
  - sb: ram_wea = 4'b0001<<addr[1:0], ram_din = {4{wdata[7:0]}}.
  - sh: ram_wea = 0011 (addr[1]=0) or 1100 (addr[1]=1), ram_din = {2{wdata[15:0]}}.
  - sw: ram_wea = 1111, ram_din = wdata.
- Loads: the selected byte or half is extended by req_signed; lw passes the word through. Loads drive ram_wea=0.
- Misaligned accesses are half with addr[0]=1, word with addr[1:0]!=0, or any access with size=11. They produce resp_err=1, excode AdEL/AdES according to we, resp_badvaddr=addr, and resp_rdata=0.
- Stores with no error respond with resp_rdata=0.

Decomposition:
- Package dmem_pkg holds:
  - size codes SZ_B, SZ_H, SZ_W;
  - EXC_ADEL = 5'h04 and EXC_ADES = 5'h05;
  - FSM state encoding.
- Sub-module dmem_align (combinational) takes size/signed/addr[1:0]/wdata/ram_dout and produces wea, din, extended rdata and misalign. The FSM and registers stay in dmem_ctrl.

Test Plan:
- RAM word 0x10 preloaded 0x8BADF00D; sw addr 0x10 data 0xDEADBEEF -> in cycle 1 ram_en=1, ram_wea=1111, ram_addr=0x10, ram_din=0xDEADBEEF; resp_valid in cycle 3 with err=0, rdata=0.
- Then lb signed addr 0x13 -> rdata 0xFFFFFFDE; lbu addr 0x13 -> 0x000000DE; lh signed addr 0x10 -> 0xFFFFBEEF.
- sh addr 0x12 data 0x00001234 -> ram_wea=1100, ram_din=0x12341234; then lw addr 0x10 -> 0x1234BEEF.
- lw addr 0x11 -> ram_en stays 0; resp err=1, excode 0x04, badvaddr 0x11. sh addr 0x13 -> excode 0x05, RAM unchanged.
- resp_ready held 0 for 5 cycles -> resp_valid=1 and resp_* constant, req_ready=0, concurrent req_valid ignored. resp_ready=1 -> IDLE next cycle.
- rst=0 during ACCESS of sw 0x20 data 0xFFFFFFFF -> ram_wea=0 in that cycle, word 0x20 unchanged, outputs 0, req_ready=1 one cycle after rst=1.
